// File: rtl/chk_clk_if.sv
// Handshake bundle for the chk_clk clock-ratio checker: stimulus inputs and status outputs.
interface chk_clk_if #(
    parameter int ERR_W = 8
);
    logic             enb;
    logic             clk_2f_in;
    logic             clk_f_in;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output enb, clk_2f_in, clk_f_in,
        input  locked, err, err_cnt
    );

    modport slave (
        input  enb, clk_2f_in, clk_f_in,
        output locked, err, err_cnt
    );
endinterface

// File: rtl/chk_clk.sv
// Clock-ratio checker for gen_clk outputs (clk_2f: 2-cycle, clk_f: 4-cycle half periods) on clk_8f.
// Define CHK_PHASE_EN to also require every clk_f rising edge to coincide with a clk_2f rising edge.
module chk_clk #(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic      clk_8f,
    input  logic      rst,
    chk_clk_if.slave  bus
);
    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(LOCK_CNT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             s2_q, s2_d, p2_q, p2_d;
    logic             sf_q, sf_d, pf_q, pf_d;
    logic [2:0]       r2_q, r2_d, rf_q, rf_d;
    logic             primed2_q, primed2_d, primedf_q, primedf_d;
    logic             bad_q, bad_d;
    logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic edge2, edgef, rise2, risef;
    logic viol2, violf, viol_ph, viol, good;

    assign edge2 = s2_q ^ p2_q;
    assign edgef = sf_q ^ pf_q;
    assign rise2 = s2_q & ~p2_q;
    assign risef = sf_q & ~pf_q;

    // A run counter sitting at 6 with no edge is about to saturate: that is the timeout.
    assign viol2 = (edge2 & primed2_q & (r2_q != 3'd1)) | (~edge2 & (r2_q == 3'd6));
    assign violf = (edgef & primedf_q & (rf_q != 3'd3)) | (~edgef & (rf_q == 3'd6));

`ifdef CHK_PHASE_EN
    assign viol_ph = risef & primed2_q & primedf_q & ~rise2;
`else
    assign viol_ph = 1'b0;
`endif

    assign viol = viol2 | violf | viol_ph;
    assign good = risef & primed2_q & primedf_q & ~bad_q & ~viol;

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        r2_d       = r2_q;
        rf_d       = rf_q;
        primed2_d  = primed2_q;
        primedf_d  = primedf_q;
        bad_d      = bad_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_d      = 1'b0;
        s2_d       = bus.clk_2f_in;
        p2_d       = s2_q;
        sf_d       = bus.clk_f_in;
        pf_d       = sf_q;

        if (!bus.enb || state_q == ST_IDLE) begin
            state_d    = bus.enb ? ST_ACQ : ST_IDLE;
            r2_d       = 3'd0;
            rf_d       = 3'd0;
            primed2_d  = 1'b0;
            primedf_d  = 1'b0;
            bad_d      = 1'b0;
            good_cnt_d = '0;
        end else begin
            r2_d      = edge2 ? 3'd0 : ((r2_q == 3'd7) ? 3'd7 : r2_q + 3'd1);
            rf_d      = edgef ? 3'd0 : ((rf_q == 3'd7) ? 3'd7 : rf_q + 3'd1);
            primed2_d = primed2_q | edge2;
            primedf_d = primedf_q | edgef;
            bad_d     = risef ? 1'b0 : (bad_q | viol);

            if (state_q == ST_LOCK) begin
                if (viol) begin
                    err_d      = 1'b1;
                    err_cnt_d  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
                    state_d    = ST_ACQ;
                    good_cnt_d = '0;
                    primed2_d  = 1'b0;
                    primedf_d  = 1'b0;
                end
            end else if (state_q == ST_ACQ) begin
                if (viol) begin
                    good_cnt_d = '0;
                end else if (good) begin
                    if (good_cnt_q == GC_LAST) begin
                        state_d    = ST_LOCK;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GC_W'(1);
                    end
                end
            end else begin
                state_d = ST_IDLE;
            end
        end

        locked_d = (state_d == ST_LOCK);
    end

    // NOTE: every flop, err_cnt included, is cleared by the asynchronous reset; there is no memory array here.
    always_ff @(posedge clk_8f or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            s2_q       <= 1'b0;
            p2_q       <= 1'b0;
            sf_q       <= 1'b0;
            pf_q       <= 1'b0;
            r2_q       <= 3'd0;
            rf_q       <= 3'd0;
            primed2_q  <= 1'b0;
            primedf_q  <= 1'b0;
            bad_q      <= 1'b0;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop see pre-edge values, independent of statement order.
            state_q    <= state_d;
            s2_q       <= s2_d;
            p2_q       <= p2_d;
            sf_q       <= sf_d;
            pf_q       <= pf_d;
            r2_q       <= r2_d;
            rf_q       <= rf_d;
            primed2_q  <= primed2_d;
            primedf_q  <= primedf_d;
            bad_q      <= bad_d;
            good_cnt_q <= good_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.locked  = locked_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_chk_clk.sv
// Directed bench for chk_clk: drives gen_clk-style patterns on the falling edge of clk_8f.
module tb_chk_clk;
    localparam int M_CLEAN  = 0;
    localparam int M_STUCK  = 1;
    localparam int M_SHIFT  = 2;
    localparam int M_GLITCH = 3;

    logic clk_8f = 1'b0;
    logic rst    = 1'b0;

    chk_clk_if #(.ERR_W(8)) bus ();

    chk_clk #(.LOCK_CNT(4), .ERR_W(8)) dut (
        .clk_8f (clk_8f),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_8f = ~clk_8f;

    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   err_pulses = 0;
    int   ph         = 0;
    int   mode       = M_CLEAN;
    logic en         = 1'b0;

    always @(posedge clk_8f) begin
        #1;
        if (bus.err === 1'b1) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clk_8f cycle: wait for the falling edge, then drive phase ph of the 8-cycle pattern.
    task automatic cyc();
        int q;
        @(negedge clk_8f);
        q = ph % 4;
        case (mode)
            M_STUCK: begin
                bus.clk_f_in  = 1'b1;
                bus.clk_2f_in = (q < 2);
            end
            M_SHIFT: begin
                bus.clk_f_in  = (ph < 4);
                bus.clk_2f_in = (q == 1) || (q == 2);
            end
            M_GLITCH: begin
                bus.clk_f_in  = (ph < 4);
                bus.clk_2f_in = (q < 2) || (ph == 2);
            end
            default: begin
                bus.clk_f_in  = (ph < 4);
                bus.clk_2f_in = (q < 2);
            end
        endcase
        bus.enb = en;
        ph = (ph + 1) % 8;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic to_ph0();
        while (ph != 0) cyc();
    endtask

    task automatic wait_lock(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            cyc();
            if (bus.locked === 1'b1) ok = 1'b1;
        end
    endtask

    // One 3-cycle clk_2f high phase (then a 1-cycle low to restore alignment); returns when err should be high.
    task automatic glitch();
        to_ph0();
        mode = M_GLITCH;
        run(4);
        mode = M_CLEAN;
        run(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int base_p;
        int base_c;
        int sat_miss;

        bus.enb       = 1'b0;
        bus.clk_2f_in = 1'b0;
        bus.clk_f_in  = 1'b0;
        run(3);
        check("rst_locked", bus.locked, 0);
        check("rst_err", bus.err, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b1;

        run(10);
        check("idle_locked", bus.locked, 0);

        // Clean lock
        en = 1'b1;
        wait_lock(48, ok);
        check("clean_lock_48", ok, 1);
        run(40);
        check("clean_still_locked", bus.locked, 1);
        check("clean_no_err", err_pulses, 0);
        check("clean_err_cnt", bus.err_cnt, 0);

        // Stuck clk_f after lock: timeout 9 cycles after the last rising edge is driven
        to_ph0();
        mode = M_STUCK;
        cyc();
        run(8);
        check("stuck_err_early", bus.err, 0);
        check("stuck_locked_early", bus.locked, 1);
        cyc();
        check("stuck_err", bus.err, 1);
        check("stuck_locked", bus.locked, 0);
        check("stuck_err_cnt", bus.err_cnt, 1);
        cyc();
        check("stuck_err_one_cycle", bus.err, 0);
        run(10);
        check("stuck_one_pulse", err_pulses, 1);
        mode = M_CLEAN;
        wait_lock(80, ok);
        check("stuck_relock", ok, 1);

        // Wrong clk_2f half period in LOCK
        base_p = err_pulses;
        glitch();
        check("glitch_err", bus.err, 1);
        check("glitch_locked", bus.locked, 0);
        check("glitch_err_cnt", bus.err_cnt, 2);
        run(4);
        check("glitch_one_pulse", err_pulses - base_p, 1);
        wait_lock(80, ok);
        check("glitch_relock", ok, 1);

        // enb drop for 5 cycles during LOCK
        base_p = err_pulses;
        en = 1'b0;
        cyc();
        cyc();
        check("enb_locked", bus.locked, 0);
        check("enb_err", bus.err, 0);
        run(3);
        en = 1'b1;
        cyc();
        check("enb_err_cnt_kept", bus.err_cnt, 2);
        check("enb_no_pulse", err_pulses - base_p, 0);
        wait_lock(80, ok);
        check("enb_relock", ok, 1);

        // Reach err_cnt = 3 while locked, then reset mid-cycle
        glitch();
        wait_lock(80, ok);
        check("pre_rst_locked", ok, 1);
        check("pre_rst_err_cnt", bus.err_cnt, 3);
        @(negedge clk_8f);
        #2 rst = 1'b0;
        #1;
        check("midrst_locked", bus.locked, 0);
        check("midrst_err_cnt", bus.err_cnt, 0);
        check("midrst_err", bus.err, 0);
        run(2);
        rst = 1'b1;
        cyc();
        check("postrst_locked", bus.locked, 0);
        wait_lock(80, ok);
        check("postrst_relock", ok, 1);

        // clk_2f delayed by one cycle relative to clk_f
        en = 1'b0;
        run(3);
        mode = M_SHIFT;
        en   = 1'b1;
        run(80);
`ifdef CHK_PHASE_EN
        check("shift_locked", bus.locked, 0);
`else
        check("shift_locked", bus.locked, 1);
`endif
        check("shift_err_cnt", bus.err_cnt, 0);

        // 300 violations in LOCK: err_cnt saturates at 255
        en   = 1'b0;
        mode = M_CLEAN;
        run(3);
        en       = 1'b1;
        sat_miss = 0;
        base_p   = err_pulses;
        base_c   = 0;
        for (int i = 0; i < 300; i++) begin
            wait_lock(80, ok);
            if (!ok) sat_miss++;
            glitch();
            if (i == 99) base_c = int'(bus.err_cnt);
        end
        run(2);
        check("sat_relocks", sat_miss, 0);
        check("sat_mid_cnt", base_c, 100);
        check("sat_pulses", err_pulses - base_p, 300);
        check("sat_err_cnt", bus.err_cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/chk_clk.md
# chk_clk

Clock-ratio checker for the `gen_clk` divider outputs. It runs on `clk_8f` and samples `clk_2f` and `clk_f` as ordinary data inputs. It verifies half-period lengths (2 and 4 `clk_8f` cycles) and, optionally, the `clk_f`/`clk_2f` rising-edge alignment. It reports lock status and counts violations, and is used in the PHY to qualify the derived clocks before the serializer/deserializer lanes are enabled.

## Interface
- `LOCK_CNT`, default 4: consecutive good `clk_f` periods required to assert `locked`.
- `ERR_W`, default 8: width of the `err_cnt` saturating counter.
- `clk_8f` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enb` in 1: checker enable.
- `clk_2f_in` in 1: divider output under test, sampled as data.
- `clk_f_in` in 1: divider output under test, sampled as data.
- `locked` out 1: ratio and phase are verified.
- `err` out 1: one-cycle pulse on each violation while in LOCK.
- `err_cnt` out ERR_W: number of LOCK violations; saturates at all-ones.

## Operation
- **Sampling.** Each input has two flops: `s` (the sample) and `p` (the previous sample). An edge is `s != p`; a rising edge is `s & ~p`.
- **Run counters.** There is one 3-bit counter `r` per input.
  - On a cycle with no edge: `r <= min(r+1, 7)`.
  - On an edge: `r` is checked, then `r <= 0`.
- **Run-length check.**
  - `clk_2f`: `r` at the edge must equal 1 (a half period of 2).
  - `clk_f`: `r` at the edge must equal 3 (a half period of 4).
  - A mismatch is a violation.
- **Priming.** The first edge of each input after entering ACQ is not checked; it sets that input's `primed` flag.
- **Timeout.** `r` going 6→7 is a violation, whether or not the input is primed. It fires once per stuck event because `r` saturates at 7.
- **Good period.** A `clk_f` rising edge is a good period when both inputs are primed and no violation occurred since the previous `clk_f` rising edge.
- **FSM states.**
  - IDLE: entered from reset or whenever `enb=0`, with priority over all other transitions. Counters `r`, `primed`, and `good_cnt` are cleared; `locked=0`.
  - ACQ: entered on `enb=1`. Each good period increments `good_cnt`. Any violation clears `good_cnt`. When `good_cnt` reaches `LOCK_CNT`, go to LOCK.
  - LOCK: `locked=1`. A violation pulses `err`, increments `err_cnt` (saturating), and returns to ACQ with `good_cnt` and `primed` cleared.
- **Violations outside LOCK.** Multiple violations in the same cycle count as one. Violations in IDLE or ACQ never touch `err` or `err_cnt`.
- **Clearing `err_cnt`.** `err_cnt` is cleared only by `rst`. Dropping `enb` does not clear it.

## Timing
- **Reset values.** While `rst=0`, asynchronously: `locked=0`, `err=0`, `err_cnt=0`, state IDLE, and all sample flops and counters 0.
- **Detection latency.** An input change captured into `s` at edge k is evaluated during cycle k. The resulting state and output update lands at edge k+1.
- **Lock latency.** `locked` rises at the edge after the `LOCK_CNT`-th good `clk_f` rising edge is seen in `s`. It falls at the edge after a violation is seen.
- **`err` pulse.** `err` is high for exactly one cycle, coincident with `locked` falling.
- **Minimum time to lock.** With clean inputs and `enb` rising, lock takes about 8·(`LOCK_CNT`+1) + 3 cycles (priming plus good periods).
- **Simultaneous events.**
  - `enb` falling in the same cycle as a violation: go to IDLE; no `err` pulse and no count.
  - `enb` low in LOCK: `locked=0` at the next edge.
- **Reset mid-lock.** Deassertion of `rst` is synchronous to `clk_8f` in the system; the block resumes in IDLE.

## Configuration
- **`CHK_PHASE_EN` defined.** Every `clk_f` rising edge must coincide with a `clk_2f` rising edge in the same sampled cycle. Otherwise it is a violation. The check is applied only when both inputs are primed.
- **`CHK_PHASE_EN` undefined.** No phase check is performed; only run lengths and timeouts are checked.

## Test plan
- **Clean lock.** Stimulus: ideal `gen_clk` pattern (2f: 2H/2L, f: 4H/4L, aligned), `enb` raised, `LOCK_CNT=4`. Required: `locked=1` within 48 cycles; `err` never pulses; `err_cnt=0`.
- **Stuck `clk_f` after lock.** Stimulus: hold `clk_f` high after lock. Required: at the 6→7 transition of its `r`, `err` pulses once, `err_cnt=1`, `locked=0`. The block relocks after the pattern is restored.
- **Wrong `clk_2f` half period.** Stimulus: in LOCK, one `clk_2f` high phase of 3 cycles. Required: one violation, `err_cnt` increments by 1, `locked` drops, then relocks after 4 good periods.
- **Phase shift.** Stimulus: `clk_2f` delayed by 1 cycle relative to `clk_f`.
  - With `CHK_PHASE_EN`: `locked` stays 0.
  - Without it: `locked=1`.
- **`enb` drop.** Stimulus: `enb=0` for 5 cycles during LOCK. Required: `locked=0` at the next edge, no `err` pulse, `err_cnt` retained. After `enb=1`, the block relocks.
- **Reset behaviour.** Stimulus: assert `rst=0` mid-cycle while locked with `err_cnt=3`. Required: immediate `locked=0`, `err_cnt=0`; saturation at 255 is verified after 300 forced violations.
